// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads IMEM combinationally and queues
// {pc, instruction} pairs for decode. Handles redirects, stalls and window faults.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 2048,
    parameter int          DEPTH      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        misalign_o,
    output logic        fetch_fault_o
);

    localparam int          CW           = $clog2(DEPTH + 1);
    localparam int          PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] WINDOW_BYTES = 32'(IMEM_WORDS) * 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic in_range;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake: decode takes the head on a cycle where inst_valid_o and
    // inst_ready_i are both high; while ready is low the head holds stable.
    assign pop      = inst_valid_o & inst_ready_i;
    assign in_range = (pc - RESET_PC) < WINDOW_BYTES;
    assign push     = !redirect_i && in_range && ((count < CW'(DEPTH)) || pop);

    assign imem_addr_o  = pc;
    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? q_inst[rd_ptr] : NOP;
    assign pc_o         = inst_valid_o ? q_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc            <= RESET_PC;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            misalign_o    <= 1'b0;
            fetch_fault_o <= 1'b0;
        end else if (redirect_i) begin
            // Flush includes any entry handed over this cycle; decode drops it.
            pc            <= {redirect_pc_i[31:2], 2'b00};
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            misalign_o    <= |redirect_pc_i[1:0];
            fetch_fault_o <= 1'b0;
        end else begin
            misalign_o    <= 1'b0;
            fetch_fault_o <= fetch_fault_o | !in_range;
            if (push) begin
                q_pc[wr_ptr]   <= pc;
                q_inst[wr_ptr] <= imem_inst_i;
                wr_ptr         <= ptr_next(wr_ptr);
                pc             <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, stalls, redirects,
// misaligned targets, end-of-window fault and reset dominance.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        misalign_o;
    logic        fetch_fault_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    always #5 clk_i = ~clk_i;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_inst_i   (imem_inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o),
        .fetch_fault_o (fetch_fault_o)
    );

    // IMEM model: two fixed words, then a pattern derived from the address
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00D0_0793;
        if (a == 32'h4) return 32'h0387_C713;
        return 32'h1000_0000 | a;
    endfunction

    always_comb imem_inst_i = imem_word(imem_addr_o);

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = rdy;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        // --- reset state
        do_reset(1'b1);
        chk("rst_valid",  32'(inst_valid_o),  32'h0);
        chk("rst_inst",   inst_o,             32'h0000_0013);
        chk("rst_pc",     pc_o,               32'h0);
        chk("rst_addr",   imem_addr_o,        32'h0);
        chk("rst_mis",    32'(misalign_o),    32'h0);
        chk("rst_fault",  32'(fetch_fault_o), 32'h0);

        // --- streaming with ready held high
        tick();
        chk("s1_valid", 32'(inst_valid_o), 32'h1);
        chk("s1_pc",    pc_o,   32'h0);
        chk("s1_inst",  inst_o, 32'h00D0_0793);
        chk("s1_addr",  imem_addr_o, 32'h4);
        tick();
        chk("s2_pc",    pc_o,   32'h4);
        chk("s2_inst",  inst_o, 32'h0387_C713);
        for (int i = 2; i < 6; i++) begin
            tick();
            chk("s_valid", 32'(inst_valid_o), 32'h1);
            chk("s_pc",    pc_o,   32'(i * 4));
            chk("s_inst",  inst_o, 32'h1000_0000 | 32'(i * 4));
        end

        // --- stall: queue fills to two entries, pc freezes at 0x8
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_valid", 32'(inst_valid_o), 32'h1);
            chk("st_pc",    pc_o,   32'h0);
            chk("st_inst",  inst_o, 32'h00D0_0793);
        end
        chk("st_addr", imem_addr_o, 32'h8);
        inst_ready_i = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        while (exp_q.size() != 0) begin
            chk("drain_valid", 32'(inst_valid_o), 32'h1);
            chk("drain_pc",    pc_o, exp_q.pop_front());
            tick();
        end

        // --- redirect with a full queue
        do_reset(1'b0);
        tick();
        tick();
        chk("rd_full_addr", imem_addr_o, 32'h8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        chk("rd_valid0", 32'(inst_valid_o), 32'h0);
        chk("rd_addr",   imem_addr_o, 32'h40);
        chk("rd_mis",    32'(misalign_o), 32'h0);
        tick();
        chk("rd_valid1", 32'(inst_valid_o), 32'h1);
        chk("rd_pc",     pc_o,   32'h40);
        chk("rd_inst",   inst_o, 32'h1000_0040);

        // --- misaligned redirect target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h43;
        tick();
        redirect_i = 1'b0;
        chk("mis_pulse", 32'(misalign_o), 32'h1);
        chk("mis_addr",  imem_addr_o, 32'h40);
        tick();
        chk("mis_clear", 32'(misalign_o), 32'h0);
        chk("mis_pc",    pc_o, 32'h40);

        // --- held redirect keeps the queue empty and reloads pc
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        tick();
        chk("hold_valid", 32'(inst_valid_o), 32'h0);
        chk("hold_addr",  imem_addr_o, 32'h100);
        redirect_i = 1'b0;

        // --- sequential run to the end of the IMEM window
        do_reset(1'b1);
        for (int i = 0; i < 2048; i++) begin
            tick();
            chk("run_pc", pc_o, 32'(i * 4));
        end
        chk("run_last_pc", pc_o, 32'h1FFC);
        chk("run_addr",    imem_addr_o, 32'h2000);
        chk("run_nofault", 32'(fetch_fault_o), 32'h0);
        tick();
        chk("flt_set",   32'(fetch_fault_o), 32'h1);
        chk("flt_valid", 32'(inst_valid_o),  32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flt_hold_valid", 32'(inst_valid_o),  32'h0);
            chk("flt_hold",       32'(fetch_fault_o), 32'h1);
            chk("flt_hold_addr",  imem_addr_o, 32'h2000);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h10;
        tick();
        redirect_i = 1'b0;
        chk("flt_clr",      32'(fetch_fault_o), 32'h0);
        chk("flt_clr_addr", imem_addr_o, 32'h10);
        tick();
        chk("flt_res_valid", 32'(inst_valid_o), 32'h1);
        chk("flt_res_pc",    pc_o, 32'h10);
        chk("flt_res_flt",   32'(fetch_fault_o), 32'h0);

        // --- redirect to an out-of-window target faults one cycle later
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h3000;
        tick();
        redirect_i = 1'b0;
        chk("oob_clear", 32'(fetch_fault_o), 32'h0);
        tick();
        chk("oob_set",   32'(fetch_fault_o), 32'h1);
        chk("oob_valid", 32'(inst_valid_o),  32'h0);

        // --- reset dominates redirect with a full queue
        do_reset(1'b0);
        tick();
        tick();
        chk("rr_full_valid", 32'(inst_valid_o), 32'h1);
        rst_i         = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h83;
        inst_ready_i  = 1'b1;
        tick();
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        chk("rr_valid", 32'(inst_valid_o),  32'h0);
        chk("rr_addr",  imem_addr_o,        32'h0);
        chk("rr_mis",   32'(misalign_o),    32'h0);
        chk("rr_fault", 32'(fetch_fault_o), 32'h0);
        tick();
        chk("rr_first_pc",   pc_o,   32'h0);
        chk("rr_first_inst", inst_o, 32'h00D0_0793);

        // --- final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
